// File: rtl/mode_sched.sv
// Guest/host mode scheduler: arms on a host command, enters guest mode on the JP
// target fetch, and traps masked I/O ports back to the host with a timed NMI pulse.
module mode_sched #(
  parameter int NMI_WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       m1_n,
  input  logic       iorq_n,
  input  logic [7:0] addr_lo,
  input  logic       new_isr,
  input  logic       last_isr_jmp,
  input  logic       io_direction,
  input  logic       cfg_we,
  input  logic       cfg_sel,
  input  logic [7:0] cfg_data,
  output logic       user_mode,
  output logic       nmi_n,
  output logic       ignore_next_isr,
  output logic [7:0] trap_port,
  output logic       trap_dir,
  output logic       trap_valid
);

  // state | meaning
  // HOST  | host owns the CPU, waiting for an arm command
  // ARM   | armed, waiting for the JP target fetch to enter guest mode
  // USER  | guest running, masked I/O ports trap
  // TRAP  | NMI pulse in progress, returns to HOST when the counter hits 0
  typedef enum logic [1:0] {
    S_HOST = 2'd0,
    S_ARM  = 2'd1,
    S_USER = 2'd2,
    S_TRAP = 2'd3
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic [7:0] trap_mask;
  logic       m1_q, iorq_q;
  logic       m1_fall, iorq_fall;
  logic       ctl_wr, mask_wr;
  logic       jp_edge, trap_hit;
  logic       cfg_unused;

  assign m1_fall   = m1_q & ~m1_n;
  assign iorq_fall = iorq_q & ~iorq_n;
  assign ctl_wr    = cfg_we & ~cfg_sel;
  assign mask_wr   = cfg_we & cfg_sel;
  assign jp_edge   = m1_fall & last_isr_jmp & new_isr;
  // m1_n low during an I/O cycle is an interrupt acknowledge, never a port access
  assign trap_hit  = (state == S_USER) & iorq_fall & m1_n & trap_mask[addr_lo[7:5]];
  assign cfg_unused = ^cfg_data[7:3];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_HOST: begin
        if (ctl_wr && cfg_data[0]) state_nxt = S_ARM;
      end
      S_ARM: begin
        if (ctl_wr && cfg_data[1]) state_nxt = S_HOST;
        else if (jp_edge)          state_nxt = S_USER;
      end
      S_USER: begin
        if (trap_hit) begin
          state_nxt = S_TRAP;
          cnt_nxt   = 8'(NMI_WIDTH - 1);
        end
      end
      S_TRAP: begin
        if (cnt == 8'd0) state_nxt = S_HOST;
        else             cnt_nxt   = cnt - 8'd1;
      end
      default: state_nxt = S_HOST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_HOST;
      cnt        <= 8'd0;
      trap_mask  <= 8'h00;
      trap_port  <= 8'h00;
      trap_dir   <= 1'b0;
      trap_valid <= 1'b0;
      m1_q       <= 1'b1;
      iorq_q     <= 1'b1;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      m1_q   <= m1_n;
      iorq_q <= iorq_n;
      if (mask_wr) trap_mask <= cfg_data;
      // a trap latched in the same cycle as a clear write leaves the record valid
      if (trap_hit) begin
        trap_port  <= addr_lo;
        trap_dir   <= io_direction;
        trap_valid <= 1'b1;
      end else if (ctl_wr && cfg_data[2]) begin
        trap_valid <= 1'b0;
      end
    end
  end

  assign user_mode       = (state == S_USER);
  assign nmi_n           = (state != S_TRAP);
  assign ignore_next_isr = (state != S_ARM);

endmodule

// File: tb/tb_mode_sched.sv
// Self-checking bench for mode_sched: table-driven cycle vectors, expected
// outputs queued at drive time and compared one clock later.
module tb_mode_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       m1_n, iorq_n;
  logic [7:0] addr_lo;
  logic       new_isr, last_isr_jmp, io_direction;
  logic       cfg_we, cfg_sel;
  logic [7:0] cfg_data;
  logic       user_mode, nmi_n, ignore_next_isr;
  logic [7:0] trap_port;
  logic       trap_dir, trap_valid;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  mode_sched #(.NMI_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .m1_n(m1_n), .iorq_n(iorq_n), .addr_lo(addr_lo),
    .new_isr(new_isr), .last_isr_jmp(last_isr_jmp), .io_direction(io_direction),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .user_mode(user_mode), .nmi_n(nmi_n), .ignore_next_isr(ignore_next_isr),
    .trap_port(trap_port), .trap_dir(trap_dir), .trap_valid(trap_valid)
  );

  typedef struct {
    string      name;
    logic       rst, m1_n, iorq_n;
    logic [7:0] addr;
    logic       dir, ni, lj, we, sel;
    logic [7:0] data;
    logic       e_user, e_nmi_n, e_ign, e_valid;
    logic [7:0] e_port;
    logic       e_dir;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  function automatic vec_t mk(string name, logic r, logic m1, logic io, logic [7:0] a,
                              logic d, logic ni, logic lj, logic we, logic sel,
                              logic [7:0] data, logic eu, logic en, logic ei,
                              logic ev, logic [7:0] ep, logic ed);
    vec_t v;
    v.name = name; v.rst = r; v.m1_n = m1; v.iorq_n = io; v.addr = a; v.dir = d;
    v.ni = ni; v.lj = lj; v.we = we; v.sel = sel; v.data = data;
    v.e_user = eu; v.e_nmi_n = en; v.e_ign = ei; v.e_valid = ev; v.e_port = ep; v.e_dir = ed;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    vec_t e;
    logic [12:0] act, exp_v;
    @(negedge clk);
    rst = v.rst; m1_n = v.m1_n; iorq_n = v.iorq_n; addr_lo = v.addr;
    io_direction = v.dir; new_isr = v.ni; last_isr_jmp = v.lj;
    cfg_we = v.we; cfg_sel = v.sel; cfg_data = v.data;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    act   = {user_mode, nmi_n, ignore_next_isr, trap_valid, trap_port, trap_dir};
    exp_v = {e.e_user, e.e_nmi_n, e.e_ign, e.e_valid, e.e_port, e.e_dir};
    tests_run++;
    if (act !== exp_v) begin
      tests_failed++;
      $display("FAIL %s: got user=%b nmi_n=%b ign=%b valid=%b port=%h dir=%b, expected user=%b nmi_n=%b ign=%b valid=%b port=%h dir=%b",
               e.name, act[12], act[11], act[10], act[9], act[8:1], act[0],
               exp_v[12], exp_v[11], exp_v[10], exp_v[9], exp_v[8:1], exp_v[0]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1);
  end

  initial begin
    rst = 1; m1_n = 1; iorq_n = 1; addr_lo = 0; io_direction = 0; new_isr = 0;
    last_isr_jmp = 0; cfg_we = 0; cfg_sel = 0; cfg_data = 0;

    //                name          rst m1 io addr  d ni lj we sel data   usr nmi ign val port  dir
    tbl.push_back(mk("reset",       1,  1, 1, 8'h00,0, 0, 0, 0, 0, 8'h00, 0, 1, 1, 0, 8'h00, 0));
    tbl.push_back(mk("idle_host",   0,  1, 1, 8'h00,0, 0, 0, 0, 0, 8'h00, 0, 1, 1, 0, 8'h00, 0));
    tbl.push_back(mk("mask_wr",     0,  1, 1, 8'h00,0, 0, 0, 1, 1, 8'h04, 0, 1, 1, 0, 8'h00, 0));
    tbl.push_back(mk("arm",         0,  1, 1, 8'h00,0, 0, 0, 1, 0, 8'h01, 0, 1, 0, 0, 8'h00, 0));
    tbl.push_back(mk("jp_edge",     0,  0, 1, 8'h00,0, 1, 1, 0, 0, 8'h00, 1, 1, 1, 0, 8'h00, 0));
    tbl.push_back(mk("user_idle",   0,  1, 1, 8'h00,0, 0, 0, 0, 0, 8'h00, 1, 1, 1, 0, 8'h00, 0));
    tbl.push_back(mk("in_unmasked", 0,  1, 0, 8'h20,1, 0, 0, 0, 0, 8'h00, 1, 1, 1, 0, 8'h00, 0));
    tbl.push_back(mk("user_idle2",  0,  1, 1, 8'h00,0, 0, 0, 0, 0, 8'h00, 1, 1, 1, 0, 8'h00, 0));
    tbl.push_back(mk("int_ack",     0,  0, 0, 8'h41,0, 0, 0, 0, 0, 8'h00, 1, 1, 1, 0, 8'h00, 0));
    tbl.push_back(mk("user_idle3",  0,  1, 1, 8'h00,0, 0, 0, 0, 0, 8'h00, 1, 1, 1, 0, 8'h00, 0));
    tbl.push_back(mk("out_trap",    0,  1, 0, 8'h41,0, 0, 0, 0, 0, 8'h00, 0, 0, 1, 1, 8'h41, 0));
    tbl.push_back(mk("nmi_2",       0,  1, 1, 8'h00,0, 0, 0, 0, 0, 8'h00, 0, 0, 1, 1, 8'h41, 0));
    tbl.push_back(mk("trap_io_ign", 0,  1, 0, 8'h42,1, 0, 0, 0, 0, 8'h00, 0, 0, 1, 1, 8'h41, 0));
    for (int i = 4; i <= 8; i++)
      tbl.push_back(mk($sformatf("nmi_%0d", i), 0, 1, 1, 8'h00, 0, 0, 0, 0, 0, 8'h00,
                       0, 0, 1, 1, 8'h41, 0));
    tbl.push_back(mk("nmi_end",     0,  1, 1, 8'h00,0, 0, 0, 0, 0, 8'h00, 0, 1, 1, 1, 8'h41, 0));
    tbl.push_back(mk("host_idle",   0,  1, 1, 8'h00,0, 0, 0, 0, 0, 8'h00, 0, 1, 1, 1, 8'h41, 0));
    foreach (tbl[i]) apply(tbl[i]);

    // clear, abort-with-priority, and partial JP conditions
    apply(mk("clear_valid",  0, 1, 1, 8'h00, 0, 0, 0, 1, 0, 8'h04, 0, 1, 1, 0, 8'h41, 0));
    apply(mk("arm2",         0, 1, 1, 8'h00, 0, 0, 0, 1, 0, 8'h01, 0, 1, 0, 0, 8'h41, 0));
    apply(mk("jp_no_newisr", 0, 0, 1, 8'h00, 0, 0, 1, 0, 0, 8'h00, 0, 1, 0, 0, 8'h41, 0));
    apply(mk("arm_idle",     0, 1, 1, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 1, 0, 0, 8'h41, 0));
    apply(mk("abort_03",     0, 1, 1, 8'h00, 0, 0, 0, 1, 0, 8'h03, 0, 1, 1, 0, 8'h41, 0));
    apply(mk("jp_in_host",   0, 0, 1, 8'h00, 0, 1, 1, 0, 0, 8'h00, 0, 1, 1, 0, 8'h41, 0));
    apply(mk("host_idle2",   0, 1, 1, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 1, 1, 0, 8'h41, 0));

    // trap coincident with a clear write, then reset mid-TRAP
    apply(mk("arm3",         0, 1, 1, 8'h00, 0, 0, 0, 1, 0, 8'h01, 0, 1, 0, 0, 8'h41, 0));
    apply(mk("jp_edge3",     0, 0, 1, 8'h00, 0, 1, 1, 0, 0, 8'h00, 1, 1, 1, 0, 8'h41, 0));
    apply(mk("arm_in_user",  0, 1, 1, 8'h00, 0, 0, 0, 1, 0, 8'h01, 1, 1, 1, 0, 8'h41, 0));
    apply(mk("trap_vs_clr",  0, 1, 0, 8'h5c, 1, 0, 0, 1, 0, 8'h04, 0, 0, 1, 1, 8'h5c, 1));
    apply(mk("trap_cont",    0, 1, 1, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 0, 1, 1, 8'h5c, 1));
    apply(mk("rst_mid_trap", 1, 1, 1, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 1, 1, 0, 8'h00, 0));
    apply(mk("post_rst",     0, 1, 1, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 1, 1, 0, 8'h00, 0));
    apply(mk("arm4",         0, 1, 1, 8'h00, 0, 0, 0, 1, 0, 8'h01, 0, 1, 0, 0, 8'h00, 0));
    apply(mk("jp_edge4",     0, 0, 1, 8'h00, 0, 1, 1, 0, 0, 8'h00, 1, 1, 1, 0, 8'h00, 0));
    apply(mk("user_idle4",   0, 1, 1, 8'h00, 0, 0, 0, 0, 0, 8'h00, 1, 1, 1, 0, 8'h00, 0));
    apply(mk("mask_cleared", 0, 1, 0, 8'h41, 0, 0, 0, 0, 0, 8'h00, 1, 1, 1, 0, 8'h00, 0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
